// File: rtl/lm_sm_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lm_sm_sequencer                                                              |
// | Expands LM/SM in fetch into one LW/SW micro-op per set bitmap bit.           |
// | Rev 1.0 - initial release                                                   |
// +----------------------------------------------------------------------------+
module lm_sm_sequencer #(
   parameter logic [3:0] OPC_LM = 4'b0110,
   parameter logic [3:0] OPC_SM = 4'b0111,
   parameter logic [3:0] OPC_LW = 4'b0100,
   parameter logic [3:0] OPC_SW = 4'b0101
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] imem_ir,
   input  logic        stall,
   input  logic        flush,
   output logic        IR_load_mux,
   output logic [15:0] new_IR_multi,
   output logic        pc_hold,
   output logic        busy
);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_SEQ  = 1'b1
   } state_t;

   state_t     state, state_nxt;
   logic [7:0] mask_q, mask_nxt;
   logic [7:0] bm_q, bm_nxt;
   logic [2:0] base_q, base_nxt;
   logic       is_lm_q, is_lm_nxt;
   logic       defer_q, defer_nxt;

   function automatic logic [2:0] lowest_bit(input logic [7:0] m);
      lowest_bit = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (m[i]) lowest_bit = 3'(i);
      end
   endfunction

   function automatic logic [2:0] count_below(input logic [7:0] m, input logic [2:0] idx);
      count_below = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (m[i] && (i < int'(idx))) count_below = count_below + 3'd1;
      end
   endfunction

   // Decode of the instruction arriving from memory (only meaningful in IDLE).
   logic [3:0] ir_opc;
   logic [2:0] ir_rb;
   logic [7:0] ir_bm;
   logic       ir_lm, ir_multi, ir_defer;
   logic       unused_bit8;

   assign ir_opc      = imem_ir[15:12];
   assign ir_rb       = imem_ir[11:9];
   assign ir_bm       = imem_ir[7:0];
   assign unused_bit8 = imem_ir[8];
   assign ir_lm       = (ir_opc == OPC_LM);
   assign ir_multi    = (ir_lm || (ir_opc == OPC_SM)) && (ir_bm != 8'd0);
   assign ir_defer    = ir_lm && ir_bm[ir_rb];

   // Source of the current micro-op: live instruction in IDLE, latched context in SEQ.
   logic       in_seq, active, src_lm, src_defer, rem_defer, more;
   logic [7:0] src_mask, src_bm, rem_mask;
   logic [2:0] src_rb, emit_reg, emit_off;

   assign in_seq    = (state == ST_SEQ);
   assign active    = in_seq || ir_multi;
   assign src_bm    = in_seq ? bm_q    : ir_bm;
   assign src_rb    = in_seq ? base_q  : ir_rb;
   assign src_lm    = in_seq ? is_lm_q : ir_lm;
   assign src_defer = in_seq ? defer_q : ir_defer;
   assign src_mask  = in_seq ? mask_q  : (ir_bm & ~(ir_defer ? (8'd1 << ir_rb) : 8'd0));

   // An empty scan mask means only the deferred base load is left.
   assign emit_reg  = (src_mask != 8'd0) ? lowest_bit(src_mask) : src_rb;
   assign emit_off  = count_below(src_bm, emit_reg);
   assign rem_mask  = src_mask & ~(8'd1 << emit_reg);
   assign rem_defer = src_defer && (src_mask != 8'd0);
   assign more      = (rem_mask != 8'd0) || rem_defer;

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= ST_IDLE;
         mask_q  <= 8'd0;
         bm_q    <= 8'd0;
         base_q  <= 3'd0;
         is_lm_q <= 1'b0;
         defer_q <= 1'b0;
      end else begin
         state   <= state_nxt;
         mask_q  <= mask_nxt;
         bm_q    <= bm_nxt;
         base_q  <= base_nxt;
         is_lm_q <= is_lm_nxt;
         defer_q <= defer_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      mask_nxt     = mask_q;
      bm_nxt       = bm_q;
      base_nxt     = base_q;
      is_lm_nxt    = is_lm_q;
      defer_nxt    = defer_q;
      IR_load_mux  = 1'b0;
      new_IR_multi = 16'h0000;
      pc_hold      = 1'b0;
      busy         = 1'b0;

      if (!reset) begin
         busy = in_seq;
         if (active) begin
            IR_load_mux  = 1'b1;
            new_IR_multi = {(src_lm ? OPC_LW : OPC_SW), emit_reg, src_rb, 3'b000, emit_off};
            pc_hold      = more;
         end
      end

      if (flush) begin
         state_nxt = ST_IDLE;
         mask_nxt  = 8'd0;
         defer_nxt = 1'b0;
      end else if (!stall && active) begin
         if (more) begin
            state_nxt = ST_SEQ;
            mask_nxt  = rem_mask;
            defer_nxt = rem_defer;
            bm_nxt    = src_bm;
            base_nxt  = src_rb;
            is_lm_nxt = src_lm;
         end else begin
            state_nxt = ST_IDLE;
            mask_nxt  = 8'd0;
            defer_nxt = 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_lm_sm_sequencer.sv
`default_nettype none
// Bench for lm_sm_sequencer: vector table, directed sequences and random
// stimulus against a list-based expansion model.
module tb_lm_sm_sequencer;

   logic        clk = 1'b0;
   logic        reset, stall, flush;
   logic [15:0] imem_ir;
   logic        IR_load_mux, pc_hold, busy;
   logic [15:0] new_IR_multi;

   int total = 0;
   int bad   = 0;

   logic [15:0] ops_q[$];
   logic [15:0] seq_q[$];

   typedef struct {
      logic [15:0] ir;
      logic        mux;
      logic        hold;
      logic [15:0] op;
   } vec_t;

   vec_t vt[12];

   always #5 clk = ~clk;

   lm_sm_sequencer dut (
      .clk          (clk),
      .reset        (reset),
      .imem_ir      (imem_ir),
      .stall        (stall),
      .flush        (flush),
      .IR_load_mux  (IR_load_mux),
      .new_IR_multi (new_IR_multi),
      .pc_hold      (pc_hold),
      .busy         (busy)
   );

   function automatic logic [18:0] outs();
      return {IR_load_mux, pc_hold, busy, new_IR_multi};
   endfunction

   task automatic check(input string name, input logic [18:0] act, input logic [18:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got mux=%0b hold=%0b busy=%0b op=%h, want mux=%0b hold=%0b busy=%0b op=%h",
                  name, act[18], act[17], act[16], act[15:0], exp[18], exp[17], exp[16], exp[15:0]);
      end
   endtask

   // One clock: drive just after the rising edge, sample on the falling edge.
   task automatic cyc(input string name, input logic [15:0] ir, input logic st, input logic fl,
                      input logic rs, input logic chk_en, input logic mux, input logic hold,
                      input logic bsy, input logic [15:0] op);
      imem_ir = ir;
      stall   = st;
      flush   = fl;
      reset   = rs;
      @(negedge clk);
      if (chk_en) check(name, outs(), {mux, hold, bsy, op});
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] mkop(input bit lm, input int r, input logic [2:0] rb,
                                        input logic [7:0] bm);
      logic [7:0] below;
      int         off;
      below = 8'((1 << r) - 1);
      off   = $countones(bm & below);
      return {(lm ? 4'h4 : 4'h5), 3'(r), rb, 3'b000, 3'(off)};
   endfunction

   // Full micro-op list for one instruction; empty if it is not an expansion.
   task automatic expand(input logic [15:0] ir);
      logic [3:0] opc;
      logic [2:0] rb;
      logic [7:0] bm;
      bit         lm, dfr;
      ops_q.delete();
      opc = ir[15:12];
      rb  = ir[11:9];
      bm  = ir[7:0];
      if (!((opc == 4'h6 || opc == 4'h7) && bm != 8'd0)) return;
      lm  = (opc == 4'h6);
      dfr = lm && bm[rb];
      for (int i = 0; i < 8; i++) begin
         if (bm[i] && !(dfr && i == int'(rb))) ops_q.push_back(mkop(lm, i, rb, bm));
      end
      if (dfr) ops_q.push_back(mkop(lm, int'(rb), rb, bm));
   endtask

   initial begin
      vt[0]  = '{16'h620D, 1'b1, 1'b1, 16'h4040};
      vt[1]  = '{16'h6407, 1'b1, 1'b1, 16'h4080};
      vt[2]  = '{16'h7680, 1'b1, 1'b0, 16'h5EC0};
      vt[3]  = '{16'h0000, 1'b0, 1'b0, 16'h0000};
      vt[4]  = '{16'h6000, 1'b0, 1'b0, 16'h0000};
      vt[5]  = '{16'h4123, 1'b0, 1'b0, 16'h0000};
      vt[6]  = '{16'h7000, 1'b0, 1'b0, 16'h0000};
      vt[7]  = '{16'h6208, 1'b1, 1'b0, 16'h4640};
      vt[8]  = '{16'h6602, 1'b1, 1'b0, 16'h42C0};
      vt[9]  = '{16'h6608, 1'b1, 1'b0, 16'h46C0};
      vt[10] = '{16'h7FFF, 1'b1, 1'b1, 16'h51C0};
      vt[11] = '{16'h6003, 1'b1, 1'b1, 16'h4201};

      // Reset forces outputs low even with an LM on the bus.
      cyc("rst0", 16'h620D, 0, 0, 1, 1, 0, 0, 0, 16'h0000);
      cyc("rst1", 16'h620D, 0, 0, 1, 1, 0, 0, 0, 16'h0000);
      cyc("idle", 16'h0000, 0, 0, 0, 1, 0, 0, 0, 16'h0000);

      // First-op decode in IDLE, held there by stall.
      foreach (vt[k])
         cyc($sformatf("vec%0d", k), vt[k].ir, 1, 0, 0, 1, vt[k].mux, vt[k].hold, 1'b0, vt[k].op);

      // LM R1 bitmap 0D; imem_ir is garbage during SEQ and must be ignored.
      cyc("lm0",  16'h620D, 0, 0, 0, 1, 1, 1, 0, 16'h4040);
      cyc("lm1",  16'h7680, 0, 0, 0, 1, 1, 1, 1, 16'h4441);
      cyc("lm2",  16'h4123, 0, 0, 0, 1, 1, 0, 1, 16'h4642);
      cyc("lm_e", 16'h0000, 0, 0, 0, 1, 0, 0, 0, 16'h0000);

      // Base register in the list is deferred to the end.
      cyc("df0",  16'h6407, 0, 0, 0, 1, 1, 1, 0, 16'h4080);
      cyc("df1",  16'h0000, 0, 0, 0, 1, 1, 1, 1, 16'h4281);
      cyc("df2",  16'h0000, 0, 0, 0, 1, 1, 0, 1, 16'h4482);
      cyc("df_e", 16'h0000, 0, 0, 0, 1, 0, 0, 0, 16'h0000);

      // Single-op SM stays in IDLE.
      cyc("sm0",  16'h7680, 0, 0, 0, 1, 1, 0, 0, 16'h5EC0);
      cyc("sm_e", 16'h0000, 0, 0, 0, 1, 0, 0, 0, 16'h0000);

      // Stall holds op1 for three cycles.
      cyc("st0",  16'h620D, 0, 0, 0, 1, 1, 1, 0, 16'h4040);
      cyc("st1a", 16'h0000, 1, 0, 0, 1, 1, 1, 1, 16'h4441);
      cyc("st1b", 16'h0000, 1, 0, 0, 1, 1, 1, 1, 16'h4441);
      cyc("st1c", 16'h0000, 0, 0, 0, 1, 1, 1, 1, 16'h4441);
      cyc("st2",  16'h0000, 0, 0, 0, 1, 1, 0, 1, 16'h4642);
      cyc("st_e", 16'h0000, 0, 0, 0, 1, 0, 0, 0, 16'h0000);

      // Flush during op1 aborts; outputs in the flush cycle are not checked.
      cyc("fl0",  16'h620D, 0, 0, 0, 1, 1, 1, 0, 16'h4040);
      cyc("fl1",  16'h0000, 0, 1, 0, 0, 0, 0, 0, 16'h0000);
      cyc("fl_e", 16'h6000, 0, 0, 0, 1, 0, 0, 0, 16'h0000);

      // Reset during op1 aborts and forces outputs low in that cycle.
      cyc("rs0",  16'h620D, 0, 0, 0, 1, 1, 1, 0, 16'h4040);
      cyc("rs1",  16'h0000, 0, 0, 1, 1, 0, 0, 0, 16'h0000);
      cyc("rs_e", 16'h6000, 0, 0, 0, 1, 0, 0, 0, 16'h0000);

      // Flush in IDLE must not start a sequence.
      cyc("fi0",  16'h620D, 0, 1, 0, 0, 0, 0, 0, 16'h0000);
      cyc("fi_e", 16'h0000, 0, 0, 0, 1, 0, 0, 0, 16'h0000);

      seq_q.delete();
      for (int c = 0; c < 600; c++) begin
         logic [15:0] ir;
         logic        st, fl;
         logic [18:0] exp;
         case ($urandom_range(0, 3))
            0:       ir = {4'h6, 12'($urandom)};
            1:       ir = {4'h7, 12'($urandom)};
            2:       ir = {4'h6, 4'($urandom), 8'($urandom) & 8'($urandom)};
            default: ir = 16'($urandom);
         endcase
         st = ($urandom_range(0, 3) == 0);
         fl = ($urandom_range(0, 24) == 0);
         imem_ir = ir;
         stall   = st;
         flush   = fl;
         reset   = 1'b0;
         @(negedge clk);
         if (fl) begin
            seq_q.delete();
         end else begin
            if (seq_q.size() == 0) begin
               expand(ir);
               if (ops_q.size() == 0) begin
                  exp = 19'd0;
               end else begin
                  exp = {1'b1, (ops_q.size() > 1), 1'b0, ops_q[0]};
                  if (!st) begin
                     void'(ops_q.pop_front());
                     seq_q = ops_q;
                  end
               end
            end else begin
               exp = {1'b1, (seq_q.size() > 1), 1'b1, seq_q[0]};
               if (!st) void'(seq_q.pop_front());
            end
            check($sformatf("rand%0d ir=%h", c, ir), outs(), exp);
         end
         @(posedge clk);
         #1;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
